// File: rtl/rev_add_seq.sv
// rev_add_seq: sequencer for a dual-rail reversible ripple adder macro.
// Each operation runs three phases of SETTLE_CYCLES cycles each: forward compute,
// reverse uncompute and all-null. Sum and carry are captured at the end of the
// forward phase, and the operands recovered in the reverse phase are checked
// against the latched ones.
// Optional feature: define REV_GOLDEN_CHECK_EN to compare the sensed sum against
// a digital adder. Without it, gold_err is tied low.
module rev_add_seq #(
    parameter int unsigned WIDTH         = 16,
    parameter int unsigned SETTLE_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             cin,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum_out,
    output logic             cout_out,
    output logic             rail_err,
    output logic             rev_err,
    output logic             gold_err,
    output logic [WIDTH-1:0] a_drv,
    output logic [WIDTH-1:0] a_not_drv,
    output logic [WIDTH-1:0] b_drv,
    output logic [WIDTH-1:0] b_not_drv,
    output logic             c0_drv,
    output logic             c0_not_drv,
    output logic             z_drv,
    output logic             z_not_drv,
    output logic [WIDTH-1:0] s_drv,
    output logic [WIDTH-1:0] s_not_drv,
    output logic             c15_drv,
    output logic             c15_not_drv,
    input  logic [WIDTH-1:0] s_sns,
    input  logic [WIDTH-1:0] s_not_sns,
    input  logic             c15_sns,
    input  logic             c15_not_sns,
    input  logic [WIDTH-1:0] a_b_sns,
    input  logic [WIDTH-1:0] a_not_b_sns,
    input  logic             c0_b_sns,
    input  logic             c0_not_b_sns
);

    localparam int unsigned CW = $clog2(SETTLE_CYCLES + 1);
    // The counter counts down to zero, so zero marks the last cycle of a phase.
    localparam logic [CW-1:0] CntLast = CW'(SETTLE_CYCLES - 1);

    typedef enum logic [2:0] {StIdle, StFwd, StRev, StNull, StDone} state_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
    logic             cin_q, cin_d, cout_q, cout_d;
    logic             rail_err_q, rail_err_d, rev_err_q, rev_err_d;
    logic             phase_last;
    logic             accept;

    assign phase_last = (cnt_q == '0);
    assign accept     = (state_q == StIdle) && start;

    // Next-state logic: phase sequencing, operand latch, capture and checks.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        a_d        = a_q;
        b_d        = b_q;
        cin_d      = cin_q;
        sum_d      = sum_q;
        cout_d     = cout_q;
        rail_err_d = rail_err_q;
        rev_err_d  = rev_err_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    a_d        = a_in;
                    b_d        = b_in;
                    cin_d      = cin;
                    rail_err_d = 1'b0;
                    rev_err_d  = 1'b0;
                    cnt_d      = CntLast;
                    state_d    = StFwd;
                end
            end
            StFwd: begin
                if (phase_last) begin
                    sum_d  = s_sns;
                    cout_d = c15_sns;
                    // Equal rails on any bit means null or a collision.
                    if ((|(~(s_sns ^ s_not_sns))) || (c15_sns == c15_not_sns)) begin
                        rail_err_d = 1'b1;
                    end
                    cnt_d   = CntLast;
                    state_d = StRev;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StRev: begin
                if (phase_last) begin
                    if ((a_b_sns != a_q) || (a_not_b_sns != ~a_q) ||
                        (c0_b_sns != cin_q) || (c0_not_b_sns != ~cin_q)) begin
                        rev_err_d = 1'b1;
                    end
                    cnt_d   = CntLast;
                    state_d = StNull;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StNull: begin
                if (phase_last) begin
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // State and datapath registers; reset returns to idle with null rails at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            a_q        <= '0;
            b_q        <= '0;
            cin_q      <= 1'b0;
            sum_q      <= '0;
            cout_q     <= 1'b0;
            rail_err_q <= 1'b0;
            rev_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            a_q        <= a_d;
            b_q        <= b_d;
            cin_q      <= cin_d;
            sum_q      <= sum_d;
            cout_q     <= cout_d;
            rail_err_q <= rail_err_d;
            rev_err_q  <= rev_err_d;
        end
    end

    // Rail drivers: null everywhere except in the phase that owns each rail pair.
    always_comb begin
        a_drv       = '0;
        a_not_drv   = '0;
        b_drv       = '0;
        b_not_drv   = '0;
        c0_drv      = 1'b0;
        c0_not_drv  = 1'b0;
        z_drv       = 1'b0;
        z_not_drv   = 1'b0;
        s_drv       = '0;
        s_not_drv   = '0;
        c15_drv     = 1'b0;
        c15_not_drv = 1'b0;
        if (state_q == StFwd) begin
            a_drv      = a_q;
            a_not_drv  = ~a_q;
            b_drv      = b_q;
            b_not_drv  = ~b_q;
            c0_drv     = cin_q;
            c0_not_drv = ~cin_q;
            z_not_drv  = 1'b1;
        end else if (state_q == StRev) begin
            s_drv       = sum_q;
            s_not_drv   = ~sum_q;
            c15_drv     = cout_q;
            c15_not_drv = ~cout_q;
        end
    end

    assign ready    = (state_q == StIdle);
    assign busy     = (state_q != StIdle);
    assign done     = (state_q == StDone);
    assign sum_out  = sum_q;
    assign cout_out = cout_q;
    assign rail_err = rail_err_q;
    assign rev_err  = rev_err_q;

`ifdef REV_GOLDEN_CHECK_EN
    logic             gold_err_q, gold_err_d;
    logic [WIDTH:0]   gold_sum;

    // Golden reference: compare the macro result with a digital adder.
    always_comb begin
        gold_sum   = {1'b0, a_q} + {1'b0, b_q} + {{WIDTH{1'b0}}, cin_q};
        gold_err_d = gold_err_q;
        if (accept) begin
            gold_err_d = 1'b0;
        end else if ((state_q == StFwd) && phase_last && (gold_sum != {c15_sns, s_sns})) begin
            gold_err_d = 1'b1;
        end
    end

    // Sticky golden mismatch flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gold_err_q <= 1'b0;
        end else begin
            gold_err_q <= gold_err_d;
        end
    end

    assign gold_err = gold_err_q;
`else
    assign gold_err = 1'b0;
`endif

endmodule

// File: tb/tb_rev_add_seq.sv
// Scoreboard bench for rev_add_seq with a behavioural model of the adder macro.
module tb_rev_add_seq;

    localparam int S = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] a_in = '0, b_in = '0;
    logic        cin = 1'b0;
    logic        ready, busy, done, cout_out, rail_err, rev_err, gold_err;
    logic [15:0] sum_out;
    logic [15:0] a_drv, a_not_drv, b_drv, b_not_drv, s_drv, s_not_drv;
    logic        c0_drv, c0_not_drv, z_drv, z_not_drv, c15_drv, c15_not_drv;
    logic [15:0] s_sns, s_not_sns, a_b_sns, a_not_b_sns;
    logic        c15_sns, c15_not_sns, c0_b_sns, c0_not_b_sns;

    // Fault injection controls for the macro model.
    logic flt_rail = 1'b0, flt_rev = 1'b0, flt_gold = 1'b0;
    logic [15:0] mem_a = '0;
    logic        mem_c = 1'b0;
    logic [16:0] fsum;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    typedef struct {
        logic [15:0] sum;
        logic        cout;
        logic        rail;
        logic        rev;
        logic        gold;
        int          cyc;
    } exp_t;
    exp_t sb[$];

`ifdef REV_GOLDEN_CHECK_EN
    localparam logic GOLD_EXP = 1'b1;
`else
    localparam logic GOLD_EXP = 1'b0;
`endif

    rev_add_seq #(.WIDTH(16), .SETTLE_CYCLES(S)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a_in(a_in), .b_in(b_in), .cin(cin),
        .ready(ready), .busy(busy), .done(done), .sum_out(sum_out), .cout_out(cout_out),
        .rail_err(rail_err), .rev_err(rev_err), .gold_err(gold_err),
        .a_drv(a_drv), .a_not_drv(a_not_drv), .b_drv(b_drv), .b_not_drv(b_not_drv),
        .c0_drv(c0_drv), .c0_not_drv(c0_not_drv), .z_drv(z_drv), .z_not_drv(z_not_drv),
        .s_drv(s_drv), .s_not_drv(s_not_drv), .c15_drv(c15_drv), .c15_not_drv(c15_not_drv),
        .s_sns(s_sns), .s_not_sns(s_not_sns), .c15_sns(c15_sns), .c15_not_sns(c15_not_sns),
        .a_b_sns(a_b_sns), .a_not_b_sns(a_not_b_sns),
        .c0_b_sns(c0_b_sns), .c0_not_b_sns(c0_not_b_sns)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Macro model: adds when forward rails are valid, echoes operands in reverse.
    always_comb begin
        fsum         = {1'b0, a_drv} + {1'b0, b_drv} + {16'd0, c0_drv};
        s_sns        = '0;
        s_not_sns    = '0;
        c15_sns      = 1'b0;
        c15_not_sns  = 1'b0;
        a_b_sns      = '0;
        a_not_b_sns  = '0;
        c0_b_sns     = 1'b0;
        c0_not_b_sns = 1'b0;
        if (c0_drv | c0_not_drv) begin
            s_sns       = fsum[15:0] ^ (flt_gold ? 16'h0080 : 16'h0000);
            s_not_sns   = ~fsum[15:0] ^ (flt_gold ? 16'h0080 : 16'h0000);
            if (flt_rail) s_not_sns[3] = s_sns[3];
            c15_sns     = fsum[16];
            c15_not_sns = ~fsum[16];
        end
        if (c15_drv | c15_not_drv) begin
            a_b_sns      = mem_a ^ (flt_rev ? 16'h0001 : 16'h0000);
            a_not_b_sns  = ~mem_a;
            c0_b_sns     = mem_c;
            c0_not_b_sns = ~mem_c;
        end
    end

    // Remember the last valid forward operands for the reverse phase.
    always @(posedge clk) begin
        if (c0_drv | c0_not_drv) begin
            mem_a <= a_drv;
            mem_c <= c0_drv;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every done pulse must match the oldest expected result.
    always @(negedge clk) begin
        exp_t e;
        if (done === 1'b1) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_done: got done=1 expected no pending op (cycle %0d)",
                         cyc);
            end else begin
                e = sb.pop_front();
                chk("done_latency", cyc, e.cyc);
                chk("sum_out", {16'd0, sum_out}, {16'd0, e.sum});
                chk("cout_out", {31'd0, cout_out}, {31'd0, e.cout});
                chk("rail_err", {31'd0, rail_err}, {31'd0, e.rail});
                chk("rev_err", {31'd0, rev_err}, {31'd0, e.rev});
                chk("gold_err", {31'd0, gold_err}, {31'd0, e.gold});
            end
        end
    end

    // mode: 0 plain, 1 rail values, 2 rail fault, 3 reverse fault, 4 golden fault,
    // 5 start pulse during REV, 6 reset in REV cycle 2.
    task automatic op(input logic [15:0] a, input logic [15:0] b, input logic c,
                      input int mode, input logic [15:0] esum, input logic ecout,
                      input logic erail, input logic erev, input logic egold);
        exp_t e;
        bit   seen;
        @(negedge clk);
        chk("accept_ready", {31'd0, ready}, 32'd1);
        a_in  = a;
        b_in  = b;
        cin   = c;
        start = 1'b1;
        if (mode != 6) begin
            // Accept edge is cyc+1; done is seen after 3S more edges (cycle T+3S+1).
            e = '{sum: esum, cout: ecout, rail: erail, rev: erev, gold: egold, cyc: cyc + 13};
            sb.push_back(e);
        end
        if (mode == 2) flt_rail = 1'b1;
        if (mode == 4) flt_gold = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 1; k <= 3 * S + 1; k++) begin
            if (k == 1) begin
                chk("busy_fwd", {31'd0, busy}, 32'd1);
                chk("rail_err_clr", {31'd0, rail_err}, 32'd0);
                chk("rev_err_clr", {31'd0, rev_err}, 32'd0);
            end
            if (mode == 1 && k == 2) begin
                chk("fwd_a_drv", {16'd0, a_drv}, 32'h0000FFFF);
                chk("fwd_a_not_drv", {16'd0, a_not_drv}, 32'h0);
                chk("fwd_z_not_drv", {31'd0, z_not_drv}, 32'd1);
            end
            if (mode == 1 && k == 10) begin
                chk("null_a_drv", {16'd0, a_drv}, 32'h0);
                chk("null_a_not_drv", {16'd0, a_not_drv}, 32'h0);
            end
            if (mode == 2 && k == 5) begin
                chk("rail_err_early", {31'd0, rail_err}, 32'd1);
                flt_rail = 1'b0;
            end
            if (mode == 3 && k == 5) flt_rev = 1'b1;
            if (mode == 3 && k == 9) begin
                chk("rev_err_early", {31'd0, rev_err}, 32'd1);
                flt_rev = 1'b0;
            end
            if (mode == 4 && k == 5) begin
                chk("gold_err_early", {31'd0, gold_err}, {31'd0, egold});
                flt_gold = 1'b0;
            end
            if (mode == 5 && k == 6) begin
                a_in  = 16'hAAAA;
                start = 1'b1;
            end
            if (mode == 5 && k == 7) start = 1'b0;
            if (mode == 6 && k == 6) begin
                rst_n = 1'b0;
                #1;
                chk("rst_a_drv", {16'd0, a_drv | a_not_drv}, 32'h0);
                chk("rst_s_drv", {16'd0, s_drv | s_not_drv}, 32'h0);
                chk("rst_c15_drv", {30'd0, c15_drv, c15_not_drv}, 32'h0);
                chk("rst_ready", {31'd0, ready}, 32'd1);
                chk("rst_sum_out", {16'd0, sum_out}, 32'h0);
                @(negedge clk);
                rst_n = 1'b1;
                return;
            end
            if (k < 3 * S + 1) @(negedge clk);
        end
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            seen = ready;
        end
        chk("ready_return", {31'd0, seen}, 32'd1);
        if (mode == 5) begin
            repeat (3) @(negedge clk);
            chk("sum_hold", {16'd0, sum_out}, {16'd0, esum});
        end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_ready", {31'd0, ready}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_sum", {15'd0, cout_out, sum_out}, 32'h0);
        chk("rst_errs", {29'd0, rail_err, rev_err, gold_err}, 32'h0);
        chk("rst_rails", {16'd0, a_drv | a_not_drv | b_drv | b_not_drv}, 32'h0);
        chk("rst_zc", {28'd0, c0_drv, c0_not_drv, z_drv, z_not_drv}, 32'h0);
        rst_n = 1'b1;

        op(16'h1234, 16'h0FFF, 1'b1, 0, 16'h2234, 1'b0, 1'b0, 1'b0, 1'b0);
        op(16'hFFFF, 16'h0001, 1'b0, 1, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0);
        op(16'h0003, 16'h0004, 1'b0, 2, 16'h0007, 1'b0, 1'b1, 1'b0, 1'b0);
        op(16'h00FF, 16'h0001, 1'b0, 0, 16'h0100, 1'b0, 1'b0, 1'b0, 1'b0);
        op(16'h5555, 16'h1111, 1'b1, 3, 16'h6667, 1'b0, 1'b0, 1'b1, 1'b0);
        // Both rails of bit 7 flipped: still complementary, but the sum is wrong.
        op(16'h0100, 16'h0200, 1'b0, 4, 16'h0380, 1'b0, 1'b0, 1'b0, GOLD_EXP);
        op(16'h0010, 16'h0020, 1'b0, 5, 16'h0030, 1'b0, 1'b0, 1'b0, 1'b0);
        op(16'h0F0F, 16'h1010, 1'b0, 6, 16'h1F1F, 1'b0, 1'b0, 1'b0, 1'b0);
        op(16'h8000, 16'h8000, 1'b1, 0, 16'h0001, 1'b1, 1'b0, 1'b0, 1'b0);

        repeat (5) @(negedge clk);
        chk("sb_drained", sb.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/rev_add_seq.md
# rev_add_seq

Sequencing controller for a WIDTH-bit dual-rail reversible ripple adder macro. It accepts operands over a start/ready handshake and drives the adder's true/complement input rails through a forward (compute) phase, then a reverse (uncompute) phase and a null phase. It captures the sum and carry-out, and checks rail integrity and backward-recovered operands. It sits between the digital PE datapath and the reversible adder hard macro.

## Interface
- WIDTH, 16: operand/sum width; must equal the adder macro width.
- SETTLE_CYCLES, 4: clock cycles per phase (FWD, REV, NULL); minimum 1.

- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  operation request; accepted only when ready=1
- a_in, b_in  in  WIDTH  operands, sampled on accept
- cin  in  1  carry-in, sampled on accept
- ready  out  1  high in IDLE only
- busy  out  1  high in FWD/REV/NULL/DONE
- done  out  1  one-cycle pulse in DONE
- sum_out  out  WIDTH  captured sum, held until next accept
- cout_out  out  1  captured carry-out
- rail_err  out  1  sticky dual-rail violation, cleared on accept
- rev_err  out  1  sticky backward-recovery mismatch, cleared on accept
- gold_err  out  1  golden-sum mismatch (see Configuration)
- a_drv, a_not_drv, b_drv, b_not_drv  out  WIDTH  forward input rails to macro
- c0_drv, c0_not_drv, z_drv, z_not_drv  out  1  carry-in and ancilla rails
- s_drv, s_not_drv  out  WIDTH  sum rails driven back during REV
- c15_drv, c15_not_drv  out  1  carry-out rails driven back during REV
- s_sns, s_not_sns  in  WIDTH  sensed sum rails
- c15_sns, c15_not_sns  in  1  sensed carry-out rails
- a_b_sns, a_not_b_sns  in  WIDTH  backward-recovered operand rails
- c0_b_sns, c0_not_b_sns  in  1  backward-recovered carry-in rails

## Operation
- Rail encoding: valid v means true rail = v and complement rail = ~v. Null means both rails = 0.
- All rail outputs carry null outside their active phase.
- States:
  - IDLE: waits for start. On start, latch a_in, b_in, cin, clear all error flags, go to FWD.
  - FWD: drive a/b/c0 rails from the latched operands; z=0, z_not=1. Counter runs SETTLE_CYCLES cycles.
  - FWD last cycle: register sum_out/cout_out from s_sns/c15_sns. Set rail_err if any bit has s_sns==s_not_sns, or c15_sns==c15_not_sns. Go to REV.
  - REV: forward rails go null. Drive s/s_not and c15/c15_not from the captured values. Runs SETTLE_CYCLES cycles.
  - REV last cycle: compare a_b_sns to latched a, a_not_b_sns to ~a, c0_b_sns to cin, c0_not_b_sns to ~cin. Any mismatch sets rev_err. Go to NULL.
  - NULL: all rails null for SETTLE_CYCLES cycles, then go to DONE.
  - DONE: done=1 for one cycle, then go to IDLE.
- start outside IDLE is ignored; no queueing.
- Phase counter width is clog2(SETTLE_CYCLES+1). It reloads on every phase entry.

## Timing
- Reset (async assert, sync release) values:
  - state=IDLE, ready=1, busy=0, done=0.
  - sum_out=0, cout_out=0, all err flags=0.
  - All drive rails null.
- Accept at edge T (start & ready).
  - FWD occupies cycles T+1..T+S (S = SETTLE_CYCLES).
  - REV occupies T+S+1..T+2S.
  - NULL occupies T+2S+1..T+3S.
  - done is high in cycle T+3S+1; ready is high from T+3S+2.
- sum_out/cout_out/rail_err are valid from cycle T+S+1. rev_err is valid from T+2S+1.
- Throughput: one operation per 3S+2 cycles.
- Overflow: sum wraps modulo 2^WIDTH; carry is reported on cout_out.
- rst_n asserted mid-operation: immediate return to IDLE. All rails go null on the same reset assertion, not waiting for a clock. No done pulse is generated.

## Configuration
- REV_GOLDEN_CHECK_EN defined: on the FWD last cycle, compute {cout,sum} = a+b+cin on the latched operands (WIDTH+1 bits). gold_err is set when this differs from the sensed values. gold_err is cleared on accept.
- REV_GOLDEN_CHECK_EN undefined: no adder is instantiated and gold_err is tied 0.

## Test plan
- WIDTH=16, S=4, a=0x1234, b=0x0FFF, cin=1 → sum_out=0x2234, cout_out=0, done exactly 13 cycles after the accept edge, all err=0.
- a=0xFFFF, b=0x0001, cin=0 → sum_out=0x0000, cout_out=1. Also check rails: during FWD, a_drv=0xFFFF and a_not_drv=0x0000; during NULL, both are 0.
- Force s_not_sns[3]=s_sns[3] during FWD → rail_err=1 at T+5, still 1 at done. The next accepted op clears it.
- Force a_b_sns[0] inverted during REV → rev_err=1, rail_err=0. With REV_GOLDEN_CHECK_EN, a wrong s_sns[7] gives gold_err=1.
- Pulse start during REV → ignored: no second done, sum_out unchanged.
- Assert rst_n low in REV cycle 2 → all rails 0, ready=1, sum_out=0, no done. A subsequent op completes normally.
